// File: rtl/inst_fetch_buffer.sv
// Instruction fetch front end: owns the fetch PC, issues reads to a synchronous
// instruction memory and buffers returned words for decode behind a valid/ready handshake.
module inst_fetch_buffer #(
    parameter int ADDR_WIDTH = 9,
    parameter int INST_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [INST_WIDTH-1:0] mem_rdata,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  buf_full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INST_WIDTH-1:0] r_data_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc_mem   [FIFO_DEPTH];

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic                  r_pending;
    logic [ADDR_WIDTH-1:0] r_pend_pc;
    logic                  r_buf_full;

    logic                  w_pop;
    logic                  w_pop_eff;
    logic                  w_push;
    logic                  w_issue;
    logic [CNT_W:0]        w_inflight;
    logic [CNT_W-1:0]      w_count_nxt;

    assign inst_valid = (r_count != '0);
    assign inst_data  = r_data_mem[r_rd_ptr];
    assign inst_pc    = r_pc_mem[r_rd_ptr];
    assign buf_full   = r_buf_full;

    assign w_pop     = inst_valid & inst_ready;
    assign w_pop_eff = w_pop & ~redirect_valid & ~reset;
    assign w_push    = r_pending & ~redirect_valid & ~reset;

    // Credit: entries held plus the read in flight, less this cycle's pop, must leave a free slot.
    assign w_inflight = (CNT_W+1)'(r_count) + (CNT_W+1)'(r_pending) - (CNT_W+1)'(w_pop);
    assign w_issue    = ~reset & en & ~redirect_valid & (w_inflight < (CNT_W+1)'(FIFO_DEPTH));

    assign mem_rd_en = w_issue;
    assign mem_addr  = reset ? '0 : r_fetch_pc;

    // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop_eff) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop_eff) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // NOTE: buffer storage has no reset; inst_valid qualifies it, and leaving it unreset lets it map to plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= mem_rdata;
            r_pc_mem[r_wr_ptr]   <= r_pend_pc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= '0;
            r_pending  <= 1'b0;
            r_pend_pc  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_buf_full <= 1'b0;
        end else if (redirect_valid) begin
            // Flush drops the buffer and the return arriving this cycle.
            r_fetch_pc <= redirect_pc;
            r_pending  <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_buf_full <= 1'b0;
        end else begin
            r_pending  <= w_issue;
            if (w_issue) begin
                r_pend_pc  <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_eff) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count    <= w_count_nxt;
            r_buf_full <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
        end
    end

endmodule
